// File: rtl/spi_adc_scanner.sv
// Serial ADC scanner: periodically clocks one conversion frame out of a serial ADC,
// steps the analog mux after each frame and presents channel-tagged results on valid/ready.
module spi_adc_scanner #(
    parameter int DATA_W  = 12,
    parameter int LEAD_W  = 4,
    parameter int CLK_DIV = 8,
    parameter int NCH     = 4,
    parameter int CH_W    = 2,
    parameter int PERIOD  = 4000
) (
    input  logic              CLK_i,
    input  logic              RSTn_i,
    input  logic              EN_i,
    input  logic              SDO_i,
    output logic              CS_o,
    output logic              SCLK_o,
    output logic [CH_W-1:0]   AMUX_o,
    output logic [DATA_W-1:0] DATA_o,
    output logic [CH_W-1:0]   CH_o,
    output logic              VALID_o,
    input  logic              READY_i,
    output logic              OVR_o,
    input  logic              OVR_CLR_i
);
    localparam int FRAME = LEAD_W + DATA_W;
    localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]        state_r;
    logic [TMR_W-1:0]  timer_r;
    logic [DIV_W-1:0]  div_r;
    logic [BIT_W-1:0]  bit_r;
    logic [DATA_W-1:0] shift_r;
    logic              cs_r;
    logic              sclk_r;
    logic [CH_W-1:0]   amux_r;
    logic [DATA_W-1:0] data_r;
    logic [CH_W-1:0]   ch_r;
    logic              valid_r;
    logic              ovr_r;

    logic              tick_s;
    logic              div_done_s;
    logic              last_bit_s;
    logic              capture_s;
    logic [CH_W-1:0]   amux_next_s;

    // Decode timer wrap, divider/bit terminal counts, capture strobe and next mux address
    always_comb begin
        tick_s      = 1'b0;
        div_done_s  = 1'b0;
        last_bit_s  = 1'b0;
        capture_s   = 1'b0;
        amux_next_s = amux_r + CH_W'(1);
        if (EN_i && (timer_r == TMR_W'(PERIOD - 1))) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if (div_r == DIV_W'(CLK_DIV - 1)) begin
            div_done_s = 1'b1;
        end else begin
            div_done_s = 1'b0;
        end
        if (bit_r == BIT_W'(FRAME - 1)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
        if ((state_r == ST_HOLD) && div_done_s) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (amux_r == CH_W'(NCH - 1)) begin
            amux_next_s = {CH_W{1'b0}};
        end else begin
            amux_next_s = amux_r + CH_W'(1);
        end
    end

    // Period timer: free-runs while enabled, held at zero while disabled
    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (!EN_i || tick_s) begin
            timer_r <= {TMR_W{1'b0}};
        end else begin
            timer_r <= timer_r + TMR_W'(1);
        end
    end

    // Frame sequencer; ticks seen outside IDLE are simply ignored
    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            state_r <= ST_IDLE;
            div_r   <= {DIV_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
            cs_r    <= 1'b1;
            sclk_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    div_r  <= {DIV_W{1'b0}};
                    bit_r  <= {BIT_W{1'b0}};
                    sclk_r <= 1'b0;
                    if (tick_s) begin
                        state_r <= ST_SETUP;
                        cs_r    <= 1'b0;
                    end else begin
                        cs_r    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (div_done_s) begin
                        div_r   <= {DIV_W{1'b0}};
                        state_r <= ST_SHIFT;
                    end else begin
                        div_r   <= div_r + DIV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (!div_done_s) begin
                        div_r <= div_r + DIV_W'(1);
                    end else if (!sclk_r) begin
                        // Leading bits fall off the top, leaving the last DATA_W bits
                        div_r   <= {DIV_W{1'b0}};
                        sclk_r  <= 1'b1;
                        shift_r <= DATA_W'({shift_r, SDO_i});
                    end else begin
                        div_r  <= {DIV_W{1'b0}};
                        sclk_r <= 1'b0;
                        if (last_bit_s) begin
                            bit_r   <= {BIT_W{1'b0}};
                            state_r <= ST_HOLD;
                        end else begin
                            bit_r   <= bit_r + BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (div_done_s) begin
                        div_r   <= {DIV_W{1'b0}};
                        cs_r    <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        div_r   <= div_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_r    <= 1'b1;
                    sclk_r  <= 1'b0;
                end
            endcase
        end
    end

    // Result register, channel stepping and valid/ready handshake
    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            data_r  <= {DATA_W{1'b0}};
            ch_r    <= {CH_W{1'b0}};
            amux_r  <= {CH_W{1'b0}};
            valid_r <= 1'b0;
        end else if (capture_s) begin
            data_r  <= shift_r;
            ch_r    <= amux_r;
            amux_r  <= amux_next_s;
            valid_r <= 1'b1;
        end else if (valid_r && READY_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Sticky overrun: a capture onto unaccepted data; set beats clear
    always_ff @(posedge CLK_i or negedge RSTn_i) begin
        if (!RSTn_i) begin
            ovr_r <= 1'b0;
        end else if (capture_s && valid_r && !READY_i) begin
            ovr_r <= 1'b1;
        end else if (OVR_CLR_i) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign CS_o    = cs_r;
    assign SCLK_o  = sclk_r;
    assign AMUX_o  = amux_r;
    assign DATA_o  = data_r;
    assign CH_o    = ch_r;
    assign VALID_o = valid_r;
    assign OVR_o   = ovr_r;

endmodule

// File: doc/spi_adc_scanner.md
Name: spi_adc_scanner

Overview:
Multi-channel serial-ADC front end for the readout top. It periodically drives CS/SCLK to clock one conversion frame out of a serial ADC's SDO line and steps an external analog-mux channel address after each frame. Each result is delivered with its channel tag on a valid/ready interface to the downstream packer or UART formatter. It generalises the fixed single-channel reader with parametrised width, framing, rate and channel count, plus output backpressure and overrun detection.

Parameters:
DATA_W, 12, ADC result bits taken from the end of the frame (1..16)
LEAD_W, 4, leading bits per frame that are discarded (0..8); FRAME = LEAD_W+DATA_W
CLK_DIV, 8, system clocks per SCLK half-period (>=1)
NCH, 4, channels scanned, 0..NCH-1 (1..16)
CH_W, 2, channel index width; must satisfy 2^CH_W >= NCH
PERIOD, 4000, system clocks between successive frame starts

Ports:
CLK_i  in  1  system clock
RSTn_i  in  1  asynchronous active-low reset
EN_i  in  1  scan enable; sampled only in IDLE
SDO_i  in  1  ADC serial data, MSB first
CS_o  out  1  ADC chip select, active low
SCLK_o  out  1  ADC serial clock, idles low
AMUX_o  out  CH_W  analog mux address of the channel being converted
DATA_o  out  DATA_W  last result
CH_o  out  CH_W  channel tag of DATA_o
VALID_o  out  1  DATA_o/CH_o valid
READY_i  in  1  consumer accepts when VALID_o && READY_i
OVR_o  out  1  sticky overrun flag
OVR_CLR_i  in  1  clears OVR_o

Behaviour:
- Reset (async, RSTn_i low): CS_o=1, SCLK_o=0, AMUX_o=0, DATA_o=0, CH_o=0, VALID_o=0, OVR_o=0, state IDLE, period timer=0, bit counter=0. Reset mid-frame aborts the frame immediately; no partial result is emitted.
- Period timer: free-runs 0..PERIOD-1 while EN_i=1 and clears to 0 while EN_i=0. A start tick occurs when it wraps to 0.
- States:
  - IDLE: CS_o=1. On a start tick with EN_i=1, go to SETUP and drive CS_o=0.
  - SETUP: hold for CLK_DIV clocks, then go to SHIFT.
  - SHIFT: run FRAME SCLK periods, each CLK_DIV clocks low followed by CLK_DIV clocks high.
    - SDO_i is shifted in on the same CLK_i edge that drives SCLK_o from 0 to 1.
    - After the FRAME-th high phase, SCLK_o returns to 0; go to HOLD.
  - HOLD: hold for CLK_DIV clocks with SCLK_o=0. Then set CS_o=1, capture the result and go to IDLE.
- Frame length: 2*CLK_DIV + 2*FRAME*CLK_DIV clocks. If PERIOD is less than the frame length, a start tick that arrives in a non-IDLE state is dropped, not queued.
- Result: the low DATA_W bits of the shift register; the first LEAD_W bits are discarded.
- Capture (on the CS_o rising edge):
  - DATA_o <= result, CH_o <= AMUX_o, VALID_o <= 1.
  - AMUX_o advances to AMUX_o+1, wrapping from NCH-1 to 0.
- Handshake:
  - VALID_o clears on the cycle after VALID_o && READY_i.
  - DATA_o and CH_o remain stable while VALID_o=1 and no handshake has occurred.
  - If a capture occurs while VALID_o=1 and READY_i=0: the new result overwrites DATA_o/CH_o, VALID_o stays 1, and OVR_o is set.
  - If a capture coincides with a handshake: no overrun; the new data is presented with VALID_o=1.
- OVR_o is sticky until OVR_CLR_i=1. If a set and a clear occur in the same cycle, the set wins.
- EN_i dropped mid-frame: the current frame completes and is captured; no further frames start.
- AMUX_o keeps its value across EN_i toggles; only reset returns it to 0.

Test Plan:
- DATA_W=12, LEAD_W=4, CLK_DIV=2, NCH=4, PERIOD=100, READY_i=1; SDO model shifts 0x09DB MSB-first on SCLK falling edges -> DATA_o=0x9DB, CH_o=0, one-cycle VALID_o, CS_o low for exactly 68 clocks.
- Same config, model returns 0x0100+ch per channel, 6 frames -> CH_o/DATA_o sequence 0/0x100, 1/0x101, 2/0x102, 3/0x103, 0/0x100, 1/0x101; frame starts exactly 100 clocks apart.
- READY_i=0 for 2 frames -> DATA_o holds the first value, is overwritten by the second, OVR_o=1. Then OVR_CLR_i pulse with READY_i=1 -> OVR_o=0 and one handshake.
- RSTn_i asserted during bit 7 of SHIFT -> CS_o=1, SCLK_o=0, VALID_o=0 with no clock edge; after release, the first frame starts after PERIOD clocks on channel 0.
- PERIOD=50 (less than 68) -> frames start every 100 clocks (every other tick); no glitch on CS_o.
- EN_i dropped 10 clocks into a frame -> that frame is delivered, then CS_o stays high; re-enabling resumes at the next channel.
